writeback_regfile: RTL and testbench
====================================

// Module: writeback_regfile
// PURPOSE
//  Final pipeline stage: consumes the MEM/WB register outputs (IR, result value, CCR-write flag).
//  Decodes the destination register from IR and commits the value to an 8x16 register file.
//  Updates CCR {C,Z}, redirects the PC on R7 writes, counts retired instructions.
//  Serves the two decode-stage read ports.
// PARAMETERS
//  DW      16  data/instruction width
//  NREG     8  architectural registers; R7 is the PC
//  CNT_W   16  width of the retired-instruction counter
// PORTS
//  clk           in   1   clock; all state updates on rising edge
//  reset         in   1   synchronous, active-high reset
//  wb_ir         in   16  instruction from MEM/WB register; NOP = 16'hF000
//  wb_value      in   16  result to commit
//  wb_carry      in   1   carry from EX, carried alongside the instruction
//  wb_ccr_write  in   1   1 = update CCR with this instruction
//  rd_addr_a     in   3   decode read port A address
//  rd_addr_b     in   3   decode read port B address
//  rd_data_a     out  16  port A data
//  rd_data_b     out  16  port B data
//  ccr           out  2   {C,Z}
//  pc_redirect   out  1   one-cycle pulse: R7 was written last cycle
//  pc_target     out  16  value written to R7; valid when pc_redirect=1
//  retired       out  16  count of non-NOP instructions committed (CNT_W)
// BEHAVIOUR
//  - Reset (sync, high): all regs=0, ccr=2'b00, pc_redirect=0, pc_target=0, retired=0.
//  - Decode of wb_ir[15:12] to a destination and write enable:
//      0000 ADD, 0010 NAND -> RC=ir[5:3]
//      0001 ADI -> RB=ir[8:6]
//      0011 LHI, 0100 LW, 1000 JAL, 1001 JLR -> RA=ir[11:9]
//      all others (SW, BEQ, 1111 NOP) -> no register write
//  - Commit: the write happens on the edge at which wb_ir is presented; latency 1 cycle.
//  - CCR: if wb_ccr_write=1 on a non-NOP instruction: C<=wb_carry, Z<=(wb_value==0).
//    CCR updates independently of the register write enable.
//  - R7 write: regs[7]<=wb_value, pc_target<=wb_value, pc_redirect<=1 for exactly one cycle.
//    Back-to-back R7 writes keep pc_redirect high with the newest target.
//  - retired increments on every wb_ir != NOP edge; wraps 16'hFFFF -> 0 silently.
//  - Reads are combinational from the array; addr 7 returns the last committed R7.
//  - Reset asserted together with a valid write: reset wins, nothing commits.
// CONFIGURATION
//  WB_BYPASS_EN defined:
//    - A read whose address matches the current-cycle destination with write enable set
//      returns wb_value (write-first). This removes the WB->ID hazard.
//  WB_BYPASS_EN undefined:
//    - Reads return array contents (read-old).
//    - The hazard unit must stall one cycle on a WB->ID match.
// STRUCTURE
//  - Shared package risc_pkg: opcode localparams (OP_ADD..OP_JLR), NOP_IR=16'hF000,
//    field slices RA/RB/RC, reg_idx_t (3-bit).
//  - One sub-module, wb_dest_decode (combinational IR -> {we, dest}), reused by the hazard unit.
//  - Array, CCR, redirect and counter logic live in this module.
// TESTING
//  1 reset: hold reset 2 cycles -> all rd_data=0, ccr=00, retired=0, pc_redirect=0.
//  2 ADD R1,R2,R3 (ir=16'h0298), value=16'h00AA, ccr_write=1, carry=1
//      -> next cycle rd R3=00AA, ccr=2'b10, retired=1.
//  3 ADI to RB=R2, value=0, ccr_write=1, carry=0 -> R2=0, ccr=2'b01.
//    Same with ccr_write=0 -> ccr unchanged.
//  4 LW RA=R7, value=16'h0040 -> pc_redirect=1 for 1 cycle, pc_target=0040, R7 reads 0040.
//  5 SW/BEQ/NOP stream of 4 instructions -> no register changes.
//    retired rises by 2 (the NOPs are not counted).
//  6 same-cycle write R5=1234 while rd_addr_a=5:
//      WB_BYPASS_EN -> rd_data_a=1234 in that cycle; else old value, then 1234 the next cycle.
//    Assert reset with a pending write -> R5 stays 0.

Source files
------------

// File: rtl/risc_pkg.sv
// risc_pkg: shared opcodes, field slices and widths for the pipeline stages
package risc_pkg;
  localparam int DW = 16;
  localparam int NREG = 8;
  localparam int CNT_W = 16;
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_ADI = 4'b0001;
  localparam logic [3:0] OP_NAND = 4'b0010;
  localparam logic [3:0] OP_LHI = 4'b0011;
  localparam logic [3:0] OP_LW = 4'b0100;
  localparam logic [3:0] OP_SW = 4'b0101;
  localparam logic [3:0] OP_JAL = 4'b1000;
  localparam logic [3:0] OP_JLR = 4'b1001;
  localparam logic [3:0] OP_BEQ = 4'b1100;
  localparam logic [DW-1:0] NOP_IR = 16'hF000;
  typedef logic [2:0] reg_idx_t;
  localparam reg_idx_t PC_IDX = 3'd7;
  function automatic reg_idx_t ra(input logic [DW-1:0] ir);
    return ir[11:9];
  endfunction
  function automatic reg_idx_t rb(input logic [DW-1:0] ir);
    return ir[8:6];
  endfunction
  function automatic reg_idx_t rc(input logic [DW-1:0] ir);
    return ir[5:3];
  endfunction
endpackage

// File: rtl/wb_dest_decode.sv
// wb_dest_decode: IR -> {write enable, destination register}, shared with the hazard unit
module wb_dest_decode
  import risc_pkg::*;
(
  input  logic [DW-1:0] ir,
  output logic          we,
  output reg_idx_t      dest
);
  logic [3:0] op;
  logic unused_bits;
  assign op = ir[15:12];
  assign unused_bits = ^ir[2:0];
  always_comb begin
    we = op inside {OP_ADD, OP_NAND, OP_ADI, OP_LHI, OP_LW, OP_JAL, OP_JLR};
    dest = (op == OP_ADD || op == OP_NAND) ? rc(ir) : (op == OP_ADI) ? rb(ir) : ra(ir);
  end
endmodule

// File: rtl/writeback_regfile.sv
// writeback_regfile: commits MEM/WB results to the 8x16 register file, CCR, PC redirect and retire count.
// Define WB_BYPASS_EN for write-first reads; otherwise reads return the array contents.
module writeback_regfile
  import risc_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [DW-1:0]    wb_ir,
  input  logic [DW-1:0]    wb_value,
  input  logic             wb_carry,
  input  logic             wb_ccr_write,
  input  reg_idx_t         rd_addr_a,
  input  reg_idx_t         rd_addr_b,
  output logic [DW-1:0]    rd_data_a,
  output logic [DW-1:0]    rd_data_b,
  output logic [1:0]       ccr,
  output logic             pc_redirect,
  output logic [DW-1:0]    pc_target,
  output logic [CNT_W-1:0] retired
);
  logic [DW-1:0] regs [NREG];
  logic we;
  reg_idx_t dest;
  logic nop;
  logic pc_we;
  wb_dest_decode u_dec (.ir(wb_ir), .we(we), .dest(dest));
  assign nop = (wb_ir == NOP_IR);
  assign pc_we = we && dest == PC_IDX;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      ccr <= 2'b00;
      pc_redirect <= 1'b0;
      pc_target <= '0;
      retired <= '0;
    end else begin
      if (we) regs[dest] <= wb_value;
      pc_redirect <= pc_we;
      if (pc_we) pc_target <= wb_value;
      if (wb_ccr_write && !nop) ccr <= {wb_carry, wb_value == '0};
      if (!nop) retired <= retired + CNT_W'(1);
    end
  end
`ifdef WB_BYPASS_EN
  assign rd_data_a = (we && dest == rd_addr_a) ? wb_value : regs[rd_addr_a];
  assign rd_data_b = (we && dest == rd_addr_b) ? wb_value : regs[rd_addr_b];
`else
  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];
`endif
endmodule

// File: tb/tb_writeback_regfile.sv
// tb_writeback_regfile: scoreboard bench for writeback_regfile (honours WB_BYPASS_EN)
module tb_writeback_regfile;
  logic clk = 0, reset = 0;
  logic [15:0] wb_ir = 16'hF000, wb_value = 0;
  logic wb_carry = 0, wb_ccr_write = 0;
  logic [2:0] rd_addr_a = 0, rd_addr_b = 0;
  logic [15:0] rd_data_a, rd_data_b, pc_target, retired;
  logic [1:0] ccr;
  logic pc_redirect;
  int n_chk = 0, n_pass = 0;
  typedef struct {
    logic [1:0]  ccr;
    logic        pr;
    logic [15:0] pt;
    logic [15:0] ret;
  } exp_t;
  exp_t q[$];
  logic [15:0] m_regs [8];
  logic [1:0]  m_ccr;
  logic        m_pr;
  logic [15:0] m_pt, m_ret;

  writeback_regfile dut (
    .clk(clk), .reset(reset), .wb_ir(wb_ir), .wb_value(wb_value), .wb_carry(wb_carry),
    .wb_ccr_write(wb_ccr_write), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .ccr(ccr), .pc_redirect(pc_redirect),
    .pc_target(pc_target), .retired(retired)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h expected=%h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic void ref_dec(input logic [15:0] ir, output bit we, output logic [2:0] d);
    case (ir[15:12])
      4'h0, 4'h2: begin we = 1; d = ir[5:3]; end
      4'h1: begin we = 1; d = ir[8:6]; end
      4'h3, 4'h4, 4'h8, 4'h9: begin we = 1; d = ir[11:9]; end
      default: begin we = 0; d = 0; end
    endcase
  endfunction

  function automatic logic [15:0] comb_read(input logic [2:0] a, input bit we, input logic [2:0] d,
                                            input logic [15:0] v);
`ifdef WB_BYPASS_EN
    return (we && d == a) ? v : m_regs[a];
`else
    return m_regs[a];
`endif
  endfunction

  task automatic step(input bit rst, input logic [15:0] ir, input logic [15:0] val,
                      input bit carry, input bit cw);
    bit we;
    logic [2:0] d;
    exp_t e, g;
    @(negedge clk);
    reset = rst; wb_ir = ir; wb_value = val; wb_carry = carry; wb_ccr_write = cw;
    ref_dec(ir, we, d);
    rd_addr_a = ir[5:3]; rd_addr_b = ir[11:9];
    #1;
    if (!rst) begin
      check("pre_rd_a", rd_data_a, comb_read(rd_addr_a, we, d, val));
      check("pre_rd_b", rd_data_b, comb_read(rd_addr_b, we, d, val));
    end
    if (rst) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 0;
      m_ccr = 0; m_pr = 0; m_pt = 0; m_ret = 0;
    end else begin
      if (we) m_regs[d] = val;
      m_pr = we && d == 3'd7;
      if (m_pr) m_pt = val;
      if (cw && ir != 16'hF000) m_ccr = {carry, val == 16'h0};
      if (ir != 16'hF000) m_ret = m_ret + 16'd1;
    end
    q.push_back('{m_ccr, m_pr, m_pt, m_ret});
    @(posedge clk);
    #1;
    reset = 0; wb_ir = 16'hF000; wb_ccr_write = 0;
    e = q.pop_front();
    g = '{ccr, pc_redirect, pc_target, retired};
    check("ccr", g.ccr, e.ccr);
    check("pc_redirect", g.pr, e.pr);
    check("pc_target", g.pt, e.pt);
    check("retired", g.ret, e.ret);
    for (int i = 0; i < 4; i++) begin
      rd_addr_a = 3'(i); rd_addr_b = 3'(i + 4);
      #1;
      check($sformatf("reg%0d", i), rd_data_a, m_regs[i]);
      check($sformatf("reg%0d", i + 4), rd_data_b, m_regs[i + 4]);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) m_regs[i] = 0;
    m_ccr = 0; m_pr = 0; m_pt = 0; m_ret = 0;
    step(1, 16'h0298, 16'h5555, 1, 1);
    step(1, 16'hF000, 16'h0, 0, 0);
    step(0, 16'h0298, 16'h00AA, 1, 1);
    step(0, 16'h1080, 16'h0000, 0, 1);
    step(0, 16'h1080, 16'h0005, 1, 0);
    step(0, 16'h4E00, 16'h0040, 0, 0);
    step(0, 16'hF000, 16'h0000, 0, 0);
    step(0, 16'h8E00, 16'h0100, 0, 0);
    step(0, 16'h9E00, 16'h0200, 0, 0);
    step(0, 16'h5000, 16'hDEAD, 1, 1);
    step(0, 16'hC000, 16'hBEEF, 0, 1);
    step(0, 16'hF000, 16'h1111, 1, 1);
    step(0, 16'hF000, 16'h2222, 0, 0);
    step(0, 16'h3A00, 16'h7777, 0, 0);
    step(0, 16'h3A28, 16'h1234, 0, 0);
    step(0, 16'h2150, 16'hFFFF, 1, 1);
    step(1, 16'h3A28, 16'h4321, 0, 0);
    step(0, 16'hF000, 16'h0000, 0, 0);
    for (int k = 0; k < 40; k++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      step(0, {op, 12'($urandom)}, 16'($urandom_range(0, 3) == 0 ? 0 : $urandom), 1'($urandom), 1'($urandom));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
